// File: rtl/uart_tx_stim.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_stim
// Purpose  : UART transmit engine with an input FIFO. Data width, parity,
//            stop-bit count and baud divider are configurable. It drives the
//            serial stimulus line of the UDM debug link.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_stim #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 32
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic [DIV_W-1:0]              divider_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  input  logic                          wr_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          ovf_o,
  output logic                          busy_o,
  output logic                          tx_o
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w  = c_addr_w + 1;
  localparam int c_idx_w  = $clog2(DATA_W);

  localparam logic [c_addr_w-1:0] c_ptr_one  = c_addr_w'(1);
  localparam logic [c_lvl_w-1:0]  c_lvl_one  = c_lvl_w'(1);
  localparam logic [c_lvl_w-1:0]  c_depth    = c_lvl_w'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0]    c_div_one  = DIV_W'(1);
  localparam logic [c_idx_w-1:0]  c_idx_one  = c_idx_w'(1);
  localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(DATA_W - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0]  r_level;
  logic [c_lvl_w-1:0]  w_level_next;
  logic                r_full;
  logic                r_ovf;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic [DATA_W-1:0]   w_head;

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [DIV_W-1:0]    r_cnt;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    w_div_eff;
  logic [c_idx_w-1:0]  r_idx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par_en;
  logic                r_par_bit;
  logic                r_stop2;
  logic                r_stop_sec;
  logic                w_cnt_zero;
  logic                w_last_bit;
  logic                w_tx;

  // Reset asserts asynchronously and releases two clocks later, in sync with clk_i
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // ---------------------------------------------------------------- FIFO
  assign w_push  = wr_i & ~r_full;
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // Storage has no reset; after reset the pointers make its contents invisible
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  // Occupancy for the next cycle; a simultaneous push and pop cancel out
  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + c_lvl_one;
      2'b01:   w_level_next = r_level - c_lvl_one;
      default: w_level_next = r_level;
    endcase
  end

  // Pointers, registered level/full and the one-cycle overflow pulse
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      r_level <= w_level_next;
      r_full  <= (w_level_next == c_depth);
      r_ovf   <= wr_i & r_full;
    end
  end

  // ---------------------------------------------------------------- Framer
  assign w_div_eff  = (divider_i == '0) ? c_div_one : divider_i;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_last_bit = (r_idx == c_last_idx);

  // State register
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= c_st_idle;
    else          r_state <= w_state_next;
  end

  // Next-state and pop decision; a frame ending with data waiting chains straight into START
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = c_st_start;
        end
      end
      c_st_start: begin
        if (w_cnt_zero) w_state_next = c_st_data;
      end
      c_st_data: begin
        if (w_cnt_zero && w_last_bit) w_state_next = r_par_en ? c_st_parity : c_st_stop;
      end
      c_st_parity: begin
        if (w_cnt_zero) w_state_next = c_st_stop;
      end
      c_st_stop: begin
        if (w_cnt_zero && (!r_stop2 || r_stop_sec)) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = c_st_start;
          end else begin
            w_state_next = c_st_idle;
          end
        end
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  // Line level for the current state
  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      c_st_idle:   w_tx = 1'b1;
      c_st_start:  w_tx = 1'b0;
      c_st_data:   w_tx = r_shift[0];
      c_st_parity: w_tx = r_par_bit;
      c_st_stop:   w_tx = 1'b1;
      default:     w_tx = 1'b1;
    endcase
  end

  // Per-frame datapath: config latched on pop, bit timer, data shifter, stop-bit phase
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt      <= '0;
      r_div      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_sec <= 1'b0;
    end else if (w_pop) begin
      r_shift    <= w_head;
      r_div      <= w_div_eff;
      r_cnt      <= w_div_eff - c_div_one;
      r_idx      <= '0;
      // 01 and 10 enable parity; bit 1 selects odd, which inverts the data XOR
      r_par_en   <= ^parity_i;
      r_par_bit  <= (^w_head) ^ parity_i[1];
      r_stop2    <= stop2_i;
      r_stop_sec <= 1'b0;
    end else if (r_state != c_st_idle) begin
      if (w_cnt_zero) begin
        r_cnt <= r_div - c_div_one;
        if (r_state == c_st_data) begin
          r_shift <= r_shift >> 1;
          r_idx   <= r_idx + c_idx_one;
        end
        if (r_state == c_st_stop) r_stop_sec <= 1'b1;
      end else begin
        r_cnt <= r_cnt - c_div_one;
      end
    end
  end

  assign tx_o    = w_tx;
  assign full_o  = r_full;
  assign level_o = r_level;
  assign ovf_o   = r_ovf;
  assign busy_o  = (r_state != c_st_idle) | (r_level != '0);

endmodule
`default_nettype wire

// File: doc/uart_tx_stim.md
Name: uart_tx_stim

Overview:
- Parametrised, synthesizable UART transmit engine with an input FIFO.
- Successor to the fixed 8N1 bit-banging used for UDM debug-link stimulus. Adds configurable data width, runtime parity mode, runtime stop-bit count, runtime baud divider and buffered multi-byte bursts.
- Sits between a host-side byte source (bench sequencer or on-chip bus master) and the rx_i pin of the sigma UDM.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- FIFO_DEPTH, 16, input FIFO entries; power of two, 2..256.
- DIV_W, 32, width of the baud divider input.

Ports:
- clk_i  input  1  system clock
- arst_n_i  input  1  asynchronous active-low reset
- divider_i  input  DIV_W  clock cycles per bit (100 MHz: 868 = 115200, 5208 = 19200)
- parity_i  input  2  00 none, 01 even, 10 odd, 11 none
- stop2_i  input  1  0 = one stop bit, 1 = two stop bits
- wr_i  input  1  push wdata_i into FIFO
- wdata_i  input  DATA_W  frame payload, LSB sent first
- full_o  output  1  FIFO full
- level_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- ovf_o  output  1  one-cycle pulse: write dropped
- busy_o  output  1  frame in progress or FIFO non-empty
- tx_o  output  1  serial line, idle high

Behaviour:
- Reset (async assert, sync release): tx_o=1, full_o=0, level_o=0, ovf_o=0, busy_o=0, FSM=IDLE, FIFO pointers=0, counters=0.
- FIFO:
  - wr_i with full_o=0 stores wdata_i; level_o increments the next cycle.
  - wr_i with full_o=1: data dropped, ovf_o=1 for exactly one cycle. This holds even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: level_o is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - full_o and level_o are registered.
- Bit timing:
  - Effective divider D = divider_i, or 1 if divider_i==0.
  - Each bit is driven on tx_o for exactly D cycles.
  - Bit counter loads D-1 and counts down to 0.
- Config sampling: divider_i, parity_i and stop2_i are latched at frame start. Changes mid-frame affect only the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_o=1. If the FIFO is non-empty, pop the head word, latch config, go to START. tx_o falls on the cycle after the pop cycle.
  - START: tx_o=0 for D cycles, then DATA with bit index 0.
  - DATA: tx_o=shift[0] for D cycles per bit, shift right, index+1. After bit DATA_W-1, go to PARITY if parity is even or odd, else STOP.
  - PARITY: even drives XOR of the data bits; odd drives its inverse. Held for D cycles, then STOP.
  - STOP: tx_o=1 for D cycles, or 2·D if stop2 is latched. At the end:
    - FIFO non-empty: pop and go directly to START. Back-to-back frames have no extra idle cycle.
    - FIFO empty: go to IDLE.
- Frame length = (1 + DATA_W + P + S)·D cycles, where P = parity present (0/1) and S = 1 or 2 stop bits.
- busy_o = (FSM != IDLE) | (level_o != 0).
- Reset mid-frame: tx_o returns to 1 immediately and FIFO contents are discarded. No glitch low after release.

Test Plan:
- Reset held, then released with parity_i=00, stop2_i=0 and no writes -> tx_o=1, busy_o=0, level_o=0 for 1000 cycles.
- divider_i=868, parity_i=00, write 0x55 -> start bit low for 868 cycles, then bits 1,0,1,0,1,0,1,0, then stop high 868 cycles. Total 8680 cycles; busy_o drops after the stop bit.
- divider_i=4, parity_i=01, then 10, write 0x07 each time -> even mode parity bit=1, odd mode parity bit=0. Frame = 11·4 = 44 cycles.
- divider_i=2, stop2_i=1, write 0xA5, 0x3C back-to-back -> second start bit begins exactly 4 cycles after the first frame's last data bit ends. No idle gap.
- FIFO_DEPTH=16, divider_i=100, write 18 words on consecutive cycles -> full_o=1 after 16 accepted words (first popped word frees one slot). ovf_o pulses for each dropped word; sent sequence matches accepted words in order.
- Assert arst_n_i low in the middle of the DATA state -> tx_o=1 within the same cycle, level_o=0. A frame after release starts cleanly with a full-length start bit.
